// File: rtl/tag_pkg.sv
// tag_pkg: tag geometry and FSM encoding shared by the tag inserter and detagger
package tag_pkg;
  localparam int TAG_OFFSET = 12;
  typedef enum logic [1:0] {IDLE, HEAD, BODY, FLUSH} state_t;
  function automatic logic [7:0] sizes_allowed(input int min_bits, input int max_bits, input int idx);
    int n = (max_bits - min_bits) / 16 + 2;
    return (idx <= 0 || idx >= n) ? 8'd0 : 8'(min_bits / 8 + 2 * (idx - 1));
  endfunction
endpackage

// File: rtl/tag_inserter_byte_shift_merge.sv
// byte_shift_merge: splices ins bytes at byte pos of a beat; bytes pushed past the beat end become the new carry
module byte_shift_merge #(
  parameter int NB = 8,
  parameter int MB = 8
) (
  input  logic [8*NB-1:0] beat,
  input  logic [7:0]      cnt,
  input  logic [8*MB-1:0] ins,
  input  logic [7:0]      shift,
  input  logic [7:0]      pos,
  output logic [8*NB-1:0] out_beat,
  output logic [8*MB-1:0] carry,
  output logic [7:0]      ovf
);
  localparam int SW = 8 * (NB + MB);
  logic [SW-1:0] bw, iw, m_pos, m_sh, sq;
  logic [8:0] sm;
  assign bw = {{(8*MB){1'b0}}, beat};
  assign iw = {{(8*NB){1'b0}}, ins};
  assign m_pos = ~({SW{1'b1}} << (8 * pos));
  assign m_sh = ~({SW{1'b1}} << (8 * shift));
  assign sq = (bw & m_pos) | ((iw & m_sh) << (8 * pos)) | ((bw >> (8 * pos)) << (8 * (pos + shift)));
  assign out_beat = sq[8*NB-1:0];
  assign carry = sq[SW-1:8*NB];
  assign sm = {1'b0, cnt} + {1'b0, shift};
  assign ovf = sm > 9'(NB) ? 8'(sm - 9'(NB)) : 8'd0;
endmodule

// File: rtl/tag_inserter.sv
// tag_inserter: inserts a per-frame tag at byte 12 of each AXI-Stream frame, shifting the rest later
module tag_inserter
  import tag_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int MAX_PACKET_LENGTH = 1522,
  parameter int MIN_TAG_SIZE_BITS = 32,
  parameter int MAX_TAG_SIZE_BITS = 64,
  localparam int NUM_TAG_SIZES      = (MAX_TAG_SIZE_BITS - MIN_TAG_SIZE_BITS) / 16 + 2,
  localparam int NUM_TAG_SIZES_LOG2 = $clog2(NUM_TAG_SIZES)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [AXIS_BUS_WIDTH-1:0]     axis_in_tdata,
  input  logic [AXIS_BUS_WIDTH/8-1:0]   axis_in_tkeep,
  input  logic                          axis_in_tlast,
  input  logic                          axis_in_tvalid,
  output logic                          axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0]     axis_out_tdata,
  output logic [AXIS_BUS_WIDTH/8-1:0]   axis_out_tkeep,
  output logic                          axis_out_tlast,
  output logic                          axis_out_tvalid,
  input  logic                          axis_out_tready,
  input  logic [MAX_TAG_SIZE_BITS-1:0]  tag_data,
  input  logic                          tag_present,
  input  logic [NUM_TAG_SIZES_LOG2-1:0] tag_mode
);
  localparam int NB = AXIS_BUS_WIDTH / 8;
  localparam int MB = MAX_TAG_SIZE_BITS / 8;
  localparam int MAX_BEATS = (MAX_PACKET_LENGTH + NB - 1) / NB + 1;
  localparam int BCW = $clog2(MAX_BEATS + 1);
  localparam logic [7:0] HEAD_POS = 8'(TAG_OFFSET % NB);
  state_t state, nxt;
  logic [MAX_TAG_SIZE_BITS-1:0] tag_q, carry_q, carry_d;
  logic [BCW-1:0] beat_cnt;
  logic [7:0] size_q, size_d, n, shift, ovf, rem_q, vcnt;
  logic [15:0] cum;
  logic in_fire, runt, head, last_d;
  logic [AXIS_BUS_WIDTH-1:0] merged, beat_d, flush_d, carry_w;
  logic [NB-1:0] keep_d, flush_keep;
  assign axis_in_tready = !areset && (!axis_out_tvalid || axis_out_tready) && state != FLUSH;
  assign in_fire = axis_in_tvalid && axis_in_tready;
  assign head = state == HEAD;
  assign size_d = sizes_allowed(MIN_TAG_SIZE_BITS, MAX_TAG_SIZE_BITS, tag_present ? int'(tag_mode) : 0);
  assign cum = 16'(beat_cnt) * 16'(NB) + 16'(n);
  assign runt = axis_in_tlast && cum <= 16'(TAG_OFFSET);
  assign shift = (state == IDLE || runt) ? 8'd0 : size_q;
  assign carry_w = AXIS_BUS_WIDTH'(carry_q);
  // valid byte count of the incoming beat (tkeep is contiguous from byte 0)
  always_comb begin
    n = '0;
    for (int i = 0; i < NB; i++) n = n + 8'(axis_in_tkeep[i]);
  end
  byte_shift_merge #(.NB(NB), .MB(MB)) u_merge (
    .beat     (axis_in_tdata),
    .cnt      (n),
    .ins      (head ? tag_q : carry_q),
    .shift    (shift),
    .pos      (head ? HEAD_POS : 8'd0),
    .out_beat (merged),
    .carry    (carry_d),
    .ovf      (ovf)
  );
  // state register
  always_ff @(posedge aclk)
    if (areset) state <= IDLE;
    else state <= nxt;
  // next state: a zero-size tag skips HEAD; a last beat that overflows needs one FLUSH beat
  always_comb begin
    nxt = state;
    if (state == FLUSH) nxt = axis_out_tready ? IDLE : FLUSH;
    else if (in_fire) nxt = axis_in_tlast ? (ovf != 8'd0 ? FLUSH : IDLE) : state == IDLE ? (size_d == 8'd0 ? BODY : HEAD) : BODY;
  end
  // next output beat, with bytes outside tkeep forced to zero
  always_comb begin
    last_d = axis_in_tlast && ovf == 8'd0;
    vcnt = last_d ? n + shift : 8'(NB);
    keep_d = ~({NB{1'b1}} << vcnt);
    flush_keep = ~({NB{1'b1}} << rem_q);
    beat_d = '0;
    flush_d = '0;
    for (int i = 0; i < NB; i++) begin
      beat_d[8*i +: 8] = keep_d[i] ? merged[8*i +: 8] : 8'd0;
      flush_d[8*i +: 8] = flush_keep[i] ? carry_w[8*i +: 8] : 8'd0;
    end
  end
  // per-frame latches, carry, beat counter and the registered output stage
  always_ff @(posedge aclk)
    if (areset) begin
      carry_q <= '0;
      beat_cnt <= '0;
      size_q <= '0;
      tag_q <= '0;
      rem_q <= '0;
      axis_out_tdata <= '0;
      axis_out_tkeep <= '0;
      axis_out_tlast <= 1'b0;
      axis_out_tvalid <= 1'b0;
    end else if (in_fire) begin
      carry_q <= carry_d;
      rem_q <= ovf;
      beat_cnt <= axis_in_tlast ? '0 : beat_cnt == BCW'(MAX_BEATS) ? beat_cnt : beat_cnt + 1'b1;
      if (state == IDLE) begin
        size_q <= size_d;
        tag_q <= tag_data;
      end
      axis_out_tdata <= beat_d;
      axis_out_tkeep <= keep_d;
      axis_out_tlast <= last_d;
      axis_out_tvalid <= 1'b1;
    end else if (state == FLUSH && axis_out_tready) begin
      axis_out_tdata <= flush_d;
      axis_out_tkeep <= flush_keep;
      axis_out_tlast <= 1'b1;
      axis_out_tvalid <= 1'b1;
    end else if (axis_out_tready) axis_out_tvalid <= 1'b0;
endmodule

// File: tb/tb_tag_inserter.sv
// tb_tag_inserter: table-driven frame checks plus flush-stall and mid-frame reset sequences
module tb_tag_inserter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic areset;
  logic [63:0] axis_in_tdata, axis_out_tdata, tag_data;
  logic [7:0] axis_in_tkeep, axis_out_tkeep;
  logic axis_in_tlast, axis_in_tvalid, axis_in_tready;
  logic axis_out_tlast, axis_out_tvalid, axis_out_tready;
  logic tag_present;
  logic [1:0] tag_mode;
  tag_inserter dut (
    .aclk(clk), .areset(areset),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep), .axis_out_tlast(axis_out_tlast),
    .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
    .tag_data(tag_data), .tag_present(tag_present), .tag_mode(tag_mode)
  );
  typedef struct {
    int len;
    bit present;
    int mode;
    logic [63:0] tag;
    int exp_len;
    int exp_beats;
    logic [7:0] exp_keep;
  } vec_t;
  vec_t tbl [12];
  int checks = 0, fails = 0, stalls = 0;
  bit rnd_ready = 1'b0;
  logic [7:0] got_q [$];
  int got_beats;
  logic [7:0] got_keep;
  bit pad_bad, got_done;
  initial begin
    axis_out_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      axis_out_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  always @(negedge clk)
    if (axis_in_tvalid && !axis_in_tready && !areset) stalls++;
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] in_byte(input int base, input int i);
    return 8'(i * 3 + base * 29 + 1);
  endfunction
  function automatic int tsize(input bit p, input int m);
    return !p ? 0 : m == 1 ? 4 : m == 2 ? 6 : m == 3 ? 8 : 0;
  endfunction
  function automatic logic [7:0] exp_byte(input vec_t v, input int base, input int k);
    int s;
    logic [63:0] t;
    s = v.len <= 12 ? 0 : tsize(v.present, v.mode);
    t = v.tag;
    if (k < 12) return in_byte(base, k);
    if (k < 12 + s) return t[8*(k-12) +: 8];
    return in_byte(base, k - s);
  endfunction
  task automatic send_frame(input vec_t v, input int base, input int nsend);
    int nb, w;
    nb = (v.len + 7) / 8;
    if (nsend > 0 && nsend < nb) nb = nsend;
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 8; i++) begin
        axis_in_tdata[8*i +: 8] = (b * 8 + i) < v.len ? in_byte(base, b * 8 + i) : 8'h00;
        axis_in_tkeep[i] = (b * 8 + i) < v.len;
      end
      axis_in_tlast = (b + 1) * 8 >= v.len;
      axis_in_tvalid = 1'b1;
      if (b == 0) begin
        tag_data = v.tag;
        tag_present = v.present;
        tag_mode = 2'(v.mode);
      end else begin
        tag_data = {$urandom, $urandom};
        tag_present = 1'($urandom);
        tag_mode = 2'($urandom);
      end
      w = 0;
      @(negedge clk);
      while (!axis_in_tready && w < 2000) begin
        @(negedge clk);
        w++;
      end
      if (!axis_in_tready) begin
        check("in_tready_timeout", {63'd0, axis_in_tready}, 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    axis_in_tvalid = 1'b0;
  endtask
  task automatic collect();
    got_q.delete();
    got_beats = 0;
    got_keep = '0;
    pad_bad = 1'b0;
    got_done = 1'b0;
    for (int c = 0; c < 5000 && !got_done; c++) begin
      @(negedge clk);
      if (axis_out_tvalid && axis_out_tready) begin
        for (int i = 0; i < 8; i++)
          if (axis_out_tkeep[i]) got_q.push_back(axis_out_tdata[8*i +: 8]);
          else if (axis_out_tdata[8*i +: 8] != 8'h00) pad_bad = 1'b1;
        got_beats++;
        if (axis_out_tlast) begin
          got_keep = axis_out_tkeep;
          got_done = 1'b1;
        end
      end
    end
  endtask
  task automatic verify(input vec_t v, input int base, input int id);
    int nbad, lim;
    collect();
    check($sformatf("f%0d_done", id), {63'd0, got_done}, 64'd1);
    check($sformatf("f%0d_len", id), 64'(got_q.size()), 64'(v.exp_len));
    check($sformatf("f%0d_beats", id), 64'(got_beats), 64'(v.exp_beats));
    check($sformatf("f%0d_last_keep", id), {56'd0, got_keep}, {56'd0, v.exp_keep});
    check($sformatf("f%0d_pad_zero", id), {63'd0, pad_bad}, 64'd0);
    nbad = 0;
    lim = got_q.size() < v.exp_len ? got_q.size() : v.exp_len;
    for (int k = 0; k < lim; k++)
      if (got_q[k] !== exp_byte(v, base, k)) nbad++;
    check($sformatf("f%0d_payload_bad_bytes", id), 64'(nbad), 64'd0);
  endtask
  initial begin
    vec_t a, b, c;
    int s0;
    areset = 1'b1;
    axis_in_tvalid = 1'b0;
    axis_in_tdata = '0;
    axis_in_tkeep = '0;
    axis_in_tlast = 1'b0;
    tag_data = '0;
    tag_present = 1'b0;
    tag_mode = '0;
    tbl[0]  = '{60, 1'b1, 1, 64'hDDCCBBAA, 64, 8, 8'hFF};
    tbl[1]  = '{64, 1'b1, 2, 64'h0000_6655_4433_2211, 70, 9, 8'h3F};
    tbl[2]  = '{60, 1'b0, 3, 64'h1122_3344_5566_7788, 60, 8, 8'h0F};
    tbl[3]  = '{1522, 1'b1, 3, 64'h8877_6655_4433_2211, 1530, 192, 8'h03};
    tbl[4]  = '{10, 1'b1, 1, 64'hCAFEF00D, 10, 2, 8'h03};
    tbl[5]  = '{60, 1'b1, 1, 64'h04030201, 64, 8, 8'hFF};
    tbl[6]  = '{12, 1'b1, 3, 64'hA1A2_A3A4_A5A6_A7A8, 12, 2, 8'h0F};
    tbl[7]  = '{13, 1'b1, 3, 64'hB1B2_B3B4_B5B6_B7B8, 21, 3, 8'h1F};
    tbl[8]  = '{64, 1'b1, 0, 64'hFFFF, 64, 8, 8'hFF};
    tbl[9]  = '{8, 1'b1, 2, 64'h1234, 8, 1, 8'hFF};
    tbl[10] = '{14, 1'b1, 2, 64'h0000_C6C5_C4C3_C2C1, 20, 3, 8'h0F};
    tbl[11] = '{61, 1'b1, 3, 64'hE1E2_E3E4_E5E6_E7E8, 69, 9, 8'h1F};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_tready", {63'd0, axis_in_tready}, 64'd0);
    check("rst_out_tvalid", {63'd0, axis_out_tvalid}, 64'd0);
    check("rst_out_tlast", {63'd0, axis_out_tlast}, 64'd0);
    check("rst_out_tkeep", {56'd0, axis_out_tkeep}, 64'd0);
    check("rst_out_tdata", axis_out_tdata, 64'd0);
    @(posedge clk);
    #1;
    areset = 1'b0;
    rnd_ready = 1'b1;
    fork
      for (int i = 0; i < 12; i++) send_frame(tbl[i], i, 0);
      for (int j = 0; j < 12; j++) verify(tbl[j], j, j);
    join
    rnd_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    a = '{64, 1'b1, 2, 64'h0000_5A5B_5C5D_5E5F, 70, 9, 8'h3F};
    b = '{16, 1'b1, 0, 64'h0, 16, 2, 8'hFF};
    s0 = stalls;
    fork
      begin
        send_frame(a, 20, 0);
        send_frame(b, 21, 0);
      end
      begin
        verify(a, 20, 100);
        verify(b, 21, 101);
      end
    join
    check("flush_stall_cycles", 64'(stalls - s0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    c = '{60, 1'b1, 1, 64'hDDCCBBAA, 64, 8, 8'hFF};
    send_frame(c, 30, 3);
    areset = 1'b1;
    @(posedge clk);
    #1;
    areset = 1'b0;
    @(negedge clk);
    check("midrst_out_tvalid", {63'd0, axis_out_tvalid}, 64'd0);
    check("midrst_in_tready", {63'd0, axis_in_tready}, 64'd1);
    @(posedge clk);
    #1;
    fork
      send_frame(c, 31, 0);
      verify(c, 31, 200);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
